// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data/instruction memory responders: FSM states,
// word width and the address alignment/range check.
package data_mem_responder_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // True when the byte address is misaligned or falls past the last stored word.
   function automatic logic dmem_addr_err(input logic [31:0] addr,
                                          input logic [31:0] depth_words);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
   endfunction

endpackage

// File: rtl/data_mem_responder_store_array.sv
// Word storage for the data memory responder: synchronous-reset register array
// with a byte-enabled write port and a combinational read port.
module dmem_store_array
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [AW-1:0]     idx,
   input  logic [WORD_W-1:0] wdata,
   input  logic [3:0]        be,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked data-memory target with programmable wait states.
// Optional byte-lane writes are enabled by defining DMEM_BYTE_LANE_EN.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [WORD_W-1:0] req_wdata,
`ifdef DMEM_BYTE_LANE_EN
   input  logic [3:0]        req_be,
`endif
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              resp_err
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high; the sender keeps valid and its payload stable until then.

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   state_t            state, next_state;
   logic [3:0]        wait_cnt;
   logic              lat_we;
   logic [31:0]       lat_addr;
   logic [WORD_W-1:0] lat_wdata;
`ifdef DMEM_BYTE_LANE_EN
   logic [3:0]        lat_be;
`endif

   logic              accept;
   logic              enter_resp;
   logic              txn_we;
   logic [31:0]       txn_addr;
   logic [WORD_W-1:0] txn_wdata;
   logic [3:0]        txn_be;
   logic              txn_err;
   logic [AW-1:0]     txn_idx;
   logic              store_we;
   logic [WORD_W-1:0] store_rdata;

   // With zero wait states RESP is entered on the accepting edge, so the
   // commit must use the live request rather than the latched copy.
   always_comb begin
      txn_we    = lat_we;
      txn_addr  = lat_addr;
      txn_wdata = lat_wdata;
`ifdef DMEM_BYTE_LANE_EN
      txn_be    = lat_be;
`else
      txn_be    = 4'hF;
`endif
      if (state == IDLE) begin
         txn_we    = req_we;
         txn_addr  = req_addr;
         txn_wdata = req_wdata;
`ifdef DMEM_BYTE_LANE_EN
         txn_be    = req_be;
`endif
      end
   end

   assign txn_err  = dmem_addr_err(txn_addr, 32'(DEPTH_WORDS));
   assign txn_idx  = txn_addr[AW+1:2];
   assign accept   = (state == IDLE) && req_valid;
   assign store_we = enter_resp && txn_we && !txn_err;

   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (wait_cnt == 4'd0) begin
               next_state = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign enter_resp = (next_state == RESP) && (state != RESP);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
`ifdef DMEM_BYTE_LANE_EN
         lat_be     <= 4'h0;
`endif
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
`ifdef DMEM_BYTE_LANE_EN
            lat_be    <= req_be;
`endif
            if (WAIT_CYCLES > 0) begin
               wait_cnt <= 4'(WAIT_CYCLES - 1);
            end
         end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (enter_resp) begin
            resp_rdata <= (txn_we || txn_err) ? '0 : store_rdata;
            resp_err   <= txn_err;
         end else if (resp_valid && resp_ready) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
         end
      end
   end

   dmem_store_array #(
      .DEPTH (DEPTH_WORDS),
      .AW    (AW)
   ) u_store (
      .clk   (CLK),
      .reset (RESET),
      .we    (store_we),
      .idx   (txn_idx),
      .wdata (txn_wdata),
      .be    (txn_be),
      .rdata (store_rdata)
   );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a word-array model.
// Byte-lane scenarios are compiled in when DMEM_BYTE_LANE_EN is defined.
module tb_data_mem_responder;

   localparam int DEPTH = 64;
   localparam int WAITC = 2;
   localparam int EXP_LAT = 1 + WAITC;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_we, req_ready;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   int total = 0;
   int bad   = 0;

   logic [31:0] model_mem [DEPTH];
   logic [31:0] exp_q [$];
   logic        exp_err_q [$];

   int          o_lat, o_busy, o_unstable;
   logic [31:0] o_rd, e_rd;
   logic        o_err, o_idle, e_err;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
      .CLK        (clk),
      .RESET      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
`ifdef DMEM_BYTE_LANE_EN
      .req_be     (req_be),
`endif
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   // Reference: byte address -> word array, errors are misaligned or past the end.
   task automatic model_req(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
      logic err;
      int   w;
      err = (addr % 4 != 0) || (addr / 4 >= DEPTH);
      w   = int'(addr / 4);
      if (!err && we) begin
         for (int b = 0; b < 4; b++) begin
`ifdef DMEM_BYTE_LANE_EN
            if (be[b]) model_mem[w][8*b +: 8] = wdata[8*b +: 8];
`else
            model_mem[w][8*b +: 8] = wdata[8*b +: 8];
`endif
         end
      end
      exp_q.push_back((we || err) ? 32'h0 : model_mem[w]);
      exp_err_q.push_back(err);
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
      exp_q.delete();
      exp_err_q.delete();
   endtask

   // Driver: issues one request from IDLE and collects what the DUT did.
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold, input logic pulse,
                          input logic rr_keep);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      @(posedge clk);
      #1 req_valid = 1'b0;
      o_lat = 0; o_busy = 0; o_unstable = 0;
      do begin
         @(negedge clk);
         o_lat++;
         if (resp_valid) break;
         if (req_ready) o_busy++;
      end while (o_lat < 64);
      o_rd = resp_rdata; o_err = resp_err;
      if (req_ready) o_busy++;
      for (int i = 0; i < hold; i++) begin
         if (pulse && i == 1) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_wdata = 32'hA5A5A5A5;
            req_be = 4'hF;
         end
         @(negedge clk);
         req_valid = 1'b0;
         if (resp_valid !== 1'b1 || resp_rdata !== o_rd || resp_err !== o_err) o_unstable++;
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = rr_keep;
      @(negedge clk);
      o_idle = req_ready && !resp_valid;
      e_rd = exp_q.pop_front();
      e_err = exp_err_q.pop_front();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b want=1", req_ready); end
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%0b want=0", resp_valid); end
      total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", resp_rdata); end
      total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", resp_err); end
   endtask

   task automatic test_read_zero();
      model_req(1'b0, 32'h0, 32'h0, 4'hF);
      run_txn(1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0, 1'b0);
      total++; if (o_lat !== EXP_LAT) begin bad++; $display("FAIL read0_latency got=%0d want=%0d", o_lat, EXP_LAT); end
      total++; if (o_rd !== e_rd || o_err !== e_err) begin bad++; $display("FAIL read0_data got=%h/%0b want=%h/%0b", o_rd, o_err, e_rd, e_err); end
      total++; if (o_idle !== 1'b1) begin bad++; $display("FAIL read0_idle got=%0b want=1", o_idle); end
   endtask

   task automatic test_write_read();
      model_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 1'b0);
      total++; if (o_rd !== e_rd || o_err !== e_err) begin bad++; $display("FAIL write_resp got=%h/%0b want=%h/%0b", o_rd, o_err, e_rd, e_err); end
      total++; if (o_busy !== 0) begin bad++; $display("FAIL write_ready_low got=%0d want=0", o_busy); end
      model_req(1'b0, 32'h10, 32'h0, 4'hF);
      run_txn(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, 1'b0);
      total++; if (o_rd !== e_rd || o_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL readback_data got=%h want=%h", o_rd, e_rd); end
      total++; if (o_err !== 1'b0) begin bad++; $display("FAIL readback_err got=%0b want=0", o_err); end
      total++; if (o_busy !== 0) begin bad++; $display("FAIL read_ready_low got=%0d want=0", o_busy); end
   endtask

   task automatic test_errors();
      logic [31:0] addrs [3];
      addrs[0] = 32'h13; addrs[1] = 32'h100; addrs[2] = 32'h10;
      for (int k = 0; k < 3; k++) begin
         model_req(1'b0, addrs[k], 32'h0, 4'hF);
         run_txn(1'b0, addrs[k], 32'h0, 4'hF, 0, 1'b0, 1'b0);
         total++; if (o_err !== e_err) begin bad++; $display("FAIL err_flag addr=%h got=%0b want=%0b", addrs[k], o_err, e_err); end
         total++; if (o_rd !== e_rd) begin bad++; $display("FAIL err_rdata addr=%h got=%h want=%h", addrs[k], o_rd, e_rd); end
         total++; if (o_lat !== EXP_LAT) begin bad++; $display("FAIL err_latency addr=%h got=%0d want=%0d", addrs[k], o_lat, EXP_LAT); end
      end
      model_req(1'b1, 32'h102, 32'h11111111, 4'hF);
      run_txn(1'b1, 32'h102, 32'h11111111, 4'hF, 0, 1'b0, 1'b0);
      total++; if (o_err !== e_err || o_rd !== e_rd) begin bad++; $display("FAIL err_write got=%h/%0b want=%h/%0b", o_rd, o_err, e_rd, e_err); end
   endtask

   task automatic test_hold();
      model_req(1'b0, 32'h10, 32'h0, 4'hF);
      run_txn(1'b0, 32'h10, 32'h0, 4'hF, 5, 1'b1, 1'b0);
      total++; if (o_unstable !== 0) begin bad++; $display("FAIL hold_stable got=%0d want=0", o_unstable); end
      total++; if (o_rd !== e_rd) begin bad++; $display("FAIL hold_rdata got=%h want=%h", o_rd, e_rd); end
      total++; if (o_idle !== 1'b1) begin bad++; $display("FAIL hold_no_accept got=%0b want=1", o_idle); end
      model_req(1'b0, 32'h0, 32'h0, 4'hF);
      run_txn(1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0, 1'b0);
      total++; if (o_rd !== e_rd) begin bad++; $display("FAIL hold_pulse_ignored got=%h want=%h", o_rd, e_rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      resp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a = 32'(k * 4 + 32'h20);
         model_req(k[0], a, 32'hC0DE0000 + 32'(k), 4'hF);
         run_txn(k[0], a, 32'hC0DE0000 + 32'(k), 4'hF, 0, 1'b0, 1'b1);
         total++; if (o_rd !== e_rd || o_lat !== EXP_LAT) begin bad++; $display("FAIL b2b_resp k=%0d got=%h lat=%0d want=%h lat=%0d", k, o_rd, o_lat, e_rd, EXP_LAT); end
         total++; if (o_idle !== 1'b1) begin bad++; $display("FAIL b2b_one_cycle k=%0d got=%0b want=1", k, o_idle); end
      end
      resp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h04; req_wdata = 32'h12345678; req_be = 4'hF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      @(negedge clk);
      total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL midreset_hs got=%0b/%0b want=1/0", req_ready, resp_valid); end
      total++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin bad++; $display("FAIL midreset_out got=%h/%0b want=0/0", resp_rdata, resp_err); end
      model_req(1'b0, 32'h04, 32'h0, 4'hF);
      run_txn(1'b0, 32'h04, 32'h0, 4'hF, 0, 1'b0, 1'b0);
      total++; if (o_rd !== e_rd || o_rd !== 32'h0) begin bad++; $display("FAIL midreset_dropped got=%h want=%h", o_rd, e_rd); end
      model_req(1'b0, 32'h10, 32'h0, 4'hF);
      run_txn(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, 1'b0);
      total++; if (o_rd !== e_rd) begin bad++; $display("FAIL midreset_cleared got=%h want=%h", o_rd, e_rd); end
   endtask

`ifdef DMEM_BYTE_LANE_EN
   task automatic test_byte_lane();
      model_req(1'b1, 32'h08, 32'hFFFFFFFF, 4'hF);
      run_txn(1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, 0, 1'b0, 1'b0);
      model_req(1'b1, 32'h08, 32'h00AB0000, 4'b0100);
      run_txn(1'b1, 32'h08, 32'h00AB0000, 4'b0100, 0, 1'b0, 1'b0);
      model_req(1'b1, 32'h08, 32'h00000000, 4'b0000);
      run_txn(1'b1, 32'h08, 32'h00000000, 4'b0000, 0, 1'b0, 1'b0);
      total++; if (o_err !== 1'b0) begin bad++; $display("FAIL be_zero_err got=%0b want=0", o_err); end
      model_req(1'b0, 32'h08, 32'h0, 4'h0);
      run_txn(1'b0, 32'h08, 32'h0, 4'h0, 0, 1'b0, 1'b0);
      total++; if (o_rd !== e_rd || o_rd !== 32'hFFABFFFF) begin bad++; $display("FAIL be_merge got=%h want=%h", o_rd, e_rd); end
   endtask
`endif

   task automatic test_random();
      logic        we;
      logic [31:0] a, d;
      logic [3:0]  be;
      int          r, h;
      logic        keep;
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
         else if (r == 1) a = 32'(DEPTH * 4) + (32'($urandom_range(0, 1000)) << 2);
         else             a = 32'($urandom_range(0, 7)) << 2;
         we   = 1'($urandom_range(0, 1));
         d    = $urandom;
`ifdef DMEM_BYTE_LANE_EN
         be   = 4'($urandom_range(0, 15));
`else
         be   = 4'hF;
`endif
         h    = $urandom_range(0, 2);
         keep = 1'($urandom_range(0, 1));
         resp_ready = keep;
         model_req(we, a, d, be);
         run_txn(we, a, d, be, keep ? 0 : h, 1'b0, 1'b0);
         total++; if (o_rd !== e_rd || o_err !== e_err) begin bad++; $display("FAIL rand_resp n=%0d addr=%h got=%h/%0b want=%h/%0b", n, a, o_rd, o_err, e_rd, e_err); end
         total++; if (o_lat !== EXP_LAT || o_busy !== 0 || o_unstable !== 0) begin bad++; $display("FAIL rand_timing n=%0d lat=%0d busy=%0d unstable=%0d want lat=%0d", n, o_lat, o_busy, o_unstable, EXP_LAT); end
      end
      resp_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_be = 4'hF; resp_ready = 1'b0;
      test_reset();
      test_read_zero();
      test_write_read();
      test_errors();
      test_hold();
      test_back_to_back();
      test_reset_mid();
`ifdef DMEM_BYTE_LANE_EN
      test_byte_lane();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
